// File: rtl/idal_seq_pkg.sv
// idal_seq_pkg: shared definitions for the idal_seq address-latch sequencer.
//   - IDAL_DATASIZE : default width of PC, SP, operand, result and address
//   - cmd_e         : command codes driven on iCmd
//   - state_e       : sequencer FSM states
package idal_seq_pkg;

    localparam int IDAL_DATASIZE = 16;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_FETCH = 3'd1,
        CMD_PUSH  = 3'd2,
        CMD_POP   = 3'd3,
        CMD_INX   = 3'd4,
        CMD_DCX   = 3'd5,
        CMD_LDPC  = 3'd6,
        CMD_LDSP  = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/idal_seq_incdec.sv
// incdec: combinational incrementer/decrementer.
//   iA  : operand
//   iS  : 0 = increment, 1 = decrement
//   oR  : iA +/- 1, modulo 2^DATASIZE
//   oF  : [0] carry (inc) or borrow (dec), [1] result is zero
module incdec #(
    parameter int DATASIZE = 16
) (
    input  logic [DATASIZE-1:0] iA,
    input  logic                iS,
    output logic [DATASIZE-1:0] oR,
    output logic [1:0]          oF
);

    logic [DATASIZE:0] ext;

    // One extra bit holds the carry-out / borrow-out of the +/-1.
    always_comb begin
        ext = '0;
        if (iS)
            ext = {1'b0, iA} - (DATASIZE+1)'(1);
        else
            ext = {1'b0, iA} + (DATASIZE+1)'(1);
    end

    assign oR    = ext[DATASIZE-1:0];
    assign oF[0] = ext[DATASIZE];
    assign oF[1] = (ext[DATASIZE-1:0] == '0);

endmodule

// File: rtl/idal_seq.sv
// idal_seq: incrementer/decrementer address-latch sequencer; owns PC and SP.
//   iClk  : clock, rising edge
//   iRst  : synchronous active-low reset
//   iReq  : command request, sampled only in IDLE
//   iCmd  : command code (cmd_e)
//   iData : operand for INX/DCX/LDPC/LDSP, sampled at acceptance
//   oAddr : latched memory address
//   oData : INX/DCX result
//   oPC   : program counter
//   oSP   : stack pointer
//   oBusy : command in progress
//   oDone : one-cycle completion pulse
//   oWrap : carry/borrow of the last inc/dec command
// Each command takes IDLE -> CALC -> WRITE; a new request may be accepted
// in the cycle oDone is high.
module idal_seq
    import idal_seq_pkg::*;
#(
    parameter int DATASIZE = IDAL_DATASIZE
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iReq,
    input  logic [2:0]          iCmd,
    input  logic [DATASIZE-1:0] iData,
    output logic [DATASIZE-1:0] oAddr,
    output logic [DATASIZE-1:0] oData,
    output logic [DATASIZE-1:0] oPC,
    output logic [DATASIZE-1:0] oSP,
    output logic                oBusy,
    output logic                oDone,
    output logic                oWrap
);

    state_e              state_q;
    cmd_e                cmd_q;
    logic [DATASIZE-1:0] opnd_q;
    logic                mode_q;
    logic [DATASIZE-1:0] res_q;
    logic                wrap_q;
    logic [DATASIZE-1:0] pc_q;
    logic [DATASIZE-1:0] sp_q;

    logic [DATASIZE-1:0] id_r;
    logic [1:0]          id_f;

    cmd_e req_cmd;
    assign req_cmd = cmd_e'(iCmd);

    incdec #(
        .DATASIZE(DATASIZE)
    ) u_incdec (
        .iA(opnd_q),
        .iS(mode_q),
        .oR(id_r),
        .oF(id_f)
    );

    assign oPC = pc_q;
    assign oSP = sp_q;

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            opnd_q  <= '0;
            mode_q  <= 1'b0;
            res_q   <= '0;
            wrap_q  <= 1'b0;
            pc_q    <= '0;
            sp_q    <= '0;
            oAddr   <= '0;
            oData   <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oWrap   <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (iReq && req_cmd != CMD_NOP) begin
                        cmd_q  <= req_cmd;
                        mode_q <= (req_cmd == CMD_PUSH) || (req_cmd == CMD_DCX);
                        case (req_cmd)
                            CMD_FETCH:         opnd_q <= pc_q;
                            CMD_PUSH, CMD_POP: opnd_q <= sp_q;
                            default:           opnd_q <= iData;
                        endcase
                        oBusy   <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    res_q  <= id_r;
                    wrap_q <= id_f[0];
                    // FETCH/POP address with the old value, PUSH with the
                    // pre-decremented one.
                    case (cmd_q)
                        CMD_FETCH, CMD_POP: oAddr <= opnd_q;
                        CMD_PUSH:           oAddr <= id_r;
                        default:            ;
                    endcase
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    case (cmd_q)
                        CMD_FETCH:          pc_q  <= res_q;
                        CMD_PUSH, CMD_POP:  sp_q  <= res_q;
                        CMD_INX, CMD_DCX:   oData <= res_q;
                        CMD_LDPC:           pc_q  <= opnd_q;
                        CMD_LDSP:           sp_q  <= opnd_q;
                        default:            ;
                    endcase
                    if (cmd_q != CMD_LDPC && cmd_q != CMD_LDSP && cmd_q != CMD_NOP)
                        oWrap <= wrap_q;
                    oBusy   <= 1'b0;
                    oDone   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    oBusy   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
